// File: rtl/multi_mode_dma.sv
// Multi-mode DMA between a byte-oriented memory bus and a CIM word array.
// Optional handshake watchdog with err output: define DMA_TIMEOUT_EN.
//
// Ports:
//   clk, rst (async, active-low)
//   start, mode, base_addr, num_words           transfer request
//   busy, done                                  status
//   mem_addr, mem_rd_en, mem_data_rd,
//   mem_wr_en, mem_data_wr                      memory bus
//   addr_col_cim, data_in_cim, web_cim,
//   web_done_cim, rd_cim, rd_done_cim,
//   data_out_cim                                CIM handshake
//   err                                         watchdog flag (DMA_TIMEOUT_EN)
module multi_mode_dma #(
    parameter int BUS_DATA_WIDTH = 8,
    parameter int CIM_DATA_WIDTH = 32,
    parameter int BUS_ADDR_WIDTH = 32,
    parameter int CIM_ADDR_WIDTH = 2,
    parameter int TIMEOUT_CYC    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      mode,
    input  logic [BUS_ADDR_WIDTH-1:0] base_addr,
    input  logic [CIM_ADDR_WIDTH:0]   num_words,
    output logic                      busy,
    output logic                      done,
    output logic [BUS_ADDR_WIDTH-1:0] mem_addr,
    output logic                      mem_rd_en,
    input  logic [BUS_DATA_WIDTH-1:0] mem_data_rd,
    output logic                      mem_wr_en,
    output logic [BUS_DATA_WIDTH-1:0] mem_data_wr,
    output logic [CIM_ADDR_WIDTH-1:0] addr_col_cim,
    output logic [CIM_DATA_WIDTH-1:0] data_in_cim,
    output logic                      web_cim,
    input  logic                      web_done_cim,
    output logic                      rd_cim,
    input  logic                      rd_done_cim,
    input  logic [CIM_DATA_WIDTH-1:0] data_out_cim
`ifdef DMA_TIMEOUT_EN
    ,
    output logic                      err
`endif
);

    localparam int PACK = CIM_DATA_WIDTH / BUS_DATA_WIDTH;
    localparam int BW   = $clog2(PACK + 1);
    localparam logic [CIM_ADDR_WIDTH:0] MAX_W = {1'b1, {CIM_ADDR_WIDTH{1'b0}}};
    localparam logic [CIM_ADDR_WIDTH:0] ONE_W = {{CIM_ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CIM_WR,
        CIM_RD,
        MEM_WR,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [BUS_ADDR_WIDTH-1:0] base_q;
    logic [CIM_ADDR_WIDTH:0]   num_q;
    logic [CIM_ADDR_WIDTH:0]   w_q;
    logic [BW-1:0]             beat_q;
    logic [CIM_DATA_WIDTH-1:0] buf_q;

    logic [CIM_ADDR_WIDTH:0]   num_clamp;
    logic [BUS_ADDR_WIDTH-1:0] addr_off;
    logic                      last_word;
    logic                      wd_hit;

    assign num_clamp = (num_words > MAX_W) ? MAX_W : num_words;
    assign last_word = ((w_q + ONE_W) == num_q);
    assign addr_off  = BUS_ADDR_WIDTH'(w_q) * BUS_ADDR_WIDTH'(PACK)
                     + BUS_ADDR_WIDTH'(beat_q);

    // Next state and strobes
    always_comb begin
        state_nx  = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        web_cim   = 1'b0;
        rd_cim    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (num_clamp == '0) state_nx = DONE;
                    else if (mode)       state_nx = CIM_RD;
                    else                 state_nx = FETCH;
                end
            end
            FETCH: begin
                // Final FETCH cycle only captures the last beat.
                if (beat_q == BW'(PACK)) state_nx = CIM_WR;
                else                     mem_rd_en = 1'b1;
            end
            CIM_WR: begin
                web_cim = 1'b1;
                if (web_done_cim) state_nx = last_word ? DONE : FETCH;
                else if (wd_hit)  state_nx = DONE;
            end
            CIM_RD: begin
                rd_cim = 1'b1;
                if (rd_done_cim)  state_nx = MEM_WR;
                else if (wd_hit)  state_nx = DONE;
            end
            MEM_WR: begin
                mem_wr_en = 1'b1;
                if (beat_q == BW'(PACK - 1))
                    state_nx = last_word ? DONE : CIM_RD;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign mem_addr     = (mem_rd_en || mem_wr_en) ? base_q + addr_off : '0;
    assign mem_data_wr  = mem_wr_en
                        ? buf_q[CIM_DATA_WIDTH-1 -: BUS_DATA_WIDTH] : '0;
    assign data_in_cim  = buf_q;
    assign addr_col_cim = w_q[CIM_ADDR_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            base_q <= '0;
            num_q  <= '0;
            w_q    <= '0;
            beat_q <= '0;
            buf_q  <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= base_addr;
                        num_q  <= num_clamp;
                        w_q    <= '0;
                        beat_q <= '0;
                    end
                end
                FETCH: begin
                    // Shift in from the LSB so beat 0 ends at the MSB.
                    if (beat_q != '0)
                        buf_q <= (buf_q << BUS_DATA_WIDTH)
                               | CIM_DATA_WIDTH'(mem_data_rd);
                    beat_q <= (state_nx == FETCH) ? beat_q + BW'(1) : '0;
                end
                CIM_WR: begin
                    if (web_done_cim) w_q <= w_q + ONE_W;
                end
                CIM_RD: begin
                    if (rd_done_cim) buf_q <= data_out_cim;
                end
                MEM_WR: begin
                    buf_q  <= buf_q << BUS_DATA_WIDTH;
                    beat_q <= (state_nx == MEM_WR) ? beat_q + BW'(1) : '0;
                    if (state_nx != MEM_WR) w_q <= w_q + ONE_W;
                end
                default: ;
            endcase
        end
    end

`ifdef DMA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] wd_q;
    logic          in_hs;
    logic          ack;

    assign in_hs  = (state == CIM_WR) || (state == CIM_RD);
    assign ack    = (state == CIM_WR) ? web_done_cim : rd_done_cim;
    assign wd_hit = in_hs && (wd_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q <= '0;
            err  <= 1'b0;
        end else begin
            wd_q <= (in_hs && state_nx == state) ? wd_q + TW'(1) : '0;
            if (state == IDLE && start) err <= 1'b0;
            else if (wd_hit && !ack)    err <= 1'b1;
        end
    end
`else
    assign wd_hit = 1'b0;
`endif

endmodule

// File: doc/multi_mode_dma.md
MULTI_MODE_DMA -- requirements
Module: multi_mode_dma

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 8, memory bus beat width in bits.
REQ-002 SHALL have parameter CIM_DATA_WIDTH, default 32, CIM word width; an integer multiple of BUS_DATA_WIDTH; PACK = CIM_DATA_WIDTH/BUS_DATA_WIDTH.
REQ-003 SHALL have parameter BUS_ADDR_WIDTH, default 32, memory byte-address width.
REQ-004 SHALL have parameter CIM_ADDR_WIDTH, default 2, CIM column-address width.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 16, handshake watchdog limit; used only under DMA_TIMEOUT_EN.
REQ-006 SHALL have the following ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  transfer request, sampled in IDLE only.
- mode  in  1  0 = LOAD (mem->CIM), 1 = STORE (CIM->mem); sampled with start.
- base_addr  in  BUS_ADDR_WIDTH  first memory byte address; sampled with start.
- num_words  in  CIM_ADDR_WIDTH+1  CIM words to move; sampled with start.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle completion pulse.
- mem_addr  out  BUS_ADDR_WIDTH  memory address.
- mem_rd_en  out  1  memory read strobe; data returns one cycle later.
- mem_data_rd  in  BUS_DATA_WIDTH  memory read data.
- mem_wr_en  out  1  memory write strobe.
- mem_data_wr  out  BUS_DATA_WIDTH  memory write data.
- addr_col_cim  out  CIM_ADDR_WIDTH  CIM column address.
- data_in_cim  out  CIM_DATA_WIDTH  word written to CIM.
- web_cim  out  1  CIM write request.
- web_done_cim  in  1  CIM write acknowledge.
- rd_cim  out  1  CIM read request.
- rd_done_cim  in  1  CIM read acknowledge; data_out_cim valid in the same cycle.
- data_out_cim  in  CIM_DATA_WIDTH  word read from CIM.
- err  out  1  timeout flag; present only under DMA_TIMEOUT_EN.

Function
REQ-007 SHALL implement the states IDLE, FETCH, CIM_WR, CIM_RD, MEM_WR and DONE.
REQ-008 IDLE: start=1 SHALL latch mode, base_addr and num_words (clamped to 2^CIM_ADDR_WIDTH), clear the word index, then go to FETCH (LOAD) or CIM_RD (STORE). num_words=0 SHALL go directly to DONE.
REQ-009 SHALL ignore start while busy=1.
REQ-010 Memory byte address for word w, beat b SHALL be base + w*PACK + b, wrapping modulo 2^BUS_ADDR_WIDTH.
REQ-011 FETCH SHALL assert mem_rd_en for PACK consecutive cycles (beats 0..PACK-1).
REQ-012 FETCH SHALL capture mem_data_rd one cycle after each strobe.
REQ-013 FETCH SHALL pack beats MSB-first: beat 0 lands in bits [CIM_DATA_WIDTH-1 -: BUS_DATA_WIDTH].
REQ-014 FETCH SHALL enter CIM_WR in the cycle after the last capture, so FETCH lasts PACK+1 cycles.
REQ-015 CIM_WR SHALL hold web_cim=1, data_in_cim and addr_col_cim=w stable until web_done_cim=1 is sampled at a rising edge; on that edge it SHALL increment w and go to FETCH, or to DONE when w+1 = num_words.
REQ-016 CIM_RD SHALL hold rd_cim=1 and addr_col_cim=w until rd_done_cim=1 is sampled at a rising edge; on that edge it SHALL capture data_out_cim and go to MEM_WR.
REQ-017 MEM_WR SHALL assert mem_wr_en for PACK cycles, driving the captured word MSB-first on mem_data_wr at the addresses of REQ-010.
REQ-018 MEM_WR SHALL then increment w and go to CIM_RD, or to DONE when w+1 = num_words.
REQ-019 An acknowledge present in the first cycle its request is high SHALL be accepted; an acknowledge while no request is high SHALL be ignored.
REQ-020 DONE SHALL pulse done=1 for exactly one cycle, then return to IDLE.
REQ-021 web_cim and rd_cim SHALL never be high together.
REQ-022 mem_rd_en and mem_wr_en SHALL never be high together.

Reset
REQ-023 rst=0 SHALL asynchronously force IDLE at any time, including mid-transfer; no done pulse SHALL result.
REQ-024 During reset, every output, counter and data register SHALL be 0.
REQ-025 After rst rises, the first start SHALL be honoured on the next rising edge.

Configuration
REQ-026 With DMA_TIMEOUT_EN defined, a watchdog SHALL count cycles spent in CIM_WR or CIM_RD.
REQ-027 When the watchdog reaches TIMEOUT_CYC with no acknowledge, the block SHALL drop the request, set err=1 and go to DONE.
REQ-028 err SHALL stay 1 until the next accepted start or reset.
REQ-029 Without DMA_TIMEOUT_EN, the err port and counter SHALL be absent and the block SHALL wait indefinitely for acknowledges.

Verification
REQ-030 LOAD, base=0, num_words=4, memory bytes 12 34 56 78 9a bc de f0 0f de cb a9 87 65 43 21, ack 2 cycles after each web_cim -> data_in_cim 0x12345678, 0x9abcdef0, 0x0fdecba9, 0x87654321 at columns 0..3, then one done pulse.
REQ-031 STORE, base=0x100, num_words=2, CIM returns 0xdeadbeef and 0x01020304 -> writes de ad be ef 01 02 03 04 to 0x100..0x107, then done.
REQ-032 num_words=0 -> done exactly 2 cycles after start; no memory or CIM strobes.
REQ-033 Reset asserted during the 2nd CIM_WR of a 4-word LOAD -> all outputs 0 immediately, no done; a fresh 1-word LOAD then completes correctly.
REQ-034 start re-pulsed while busy -> ignored, original transfer unchanged; base=0xFFFFFFFE with a 1-word LOAD -> addresses wrap to FFFFFFFE, FFFFFFFF, 0, 1.
REQ-035 DMA_TIMEOUT_EN, TIMEOUT_CYC=16, web_done_cim held 0 -> web_cim drops after 16 cycles, err=1, done pulses; the next start clears err.
